// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// Latency: none; this is wiring only.
// Backpressure: memory stalls arrive on mem_ready, and every other signal is a level.
interface multi_cycle_ctrl_if;
    // Datapath to controller
    logic [5:0] op;            // IR[31:26]
    logic       zero;          // ALU zero flag
    logic       mem_ready;     // memory access completes this cycle

    // Controller to datapath
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;         // debug view of the current state

    // Controller side
    modport master (
        input  op, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    // Datapath side
    modport slave (
        output op, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore FSM sequencing the multi-cycle MIPS datapath (R-type, lw, sw, beq, j).
// Latency: R=4, lw=5, sw=4, beq=3, j=3 cycles, plus one per mem_ready=0 cycle in a memory state.
// Backpressure: IF/MRD/MWR hold until mem_ready when MEM_WAIT_EN=1, and never stall when it is 0.
module multi_cycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_cycle_ctrl_if.master     bus
);

    localparam logic [3:0] S_IF   = 4'd0;
    localparam logic [3:0] S_ID   = 4'd1;
    localparam logic [3:0] S_MADR = 4'd2;
    localparam logic [3:0] S_MRD  = 4'd3;
    localparam logic [3:0] S_MWB  = 4'd4;
    localparam logic [3:0] S_MWR  = 4'd5;
    localparam logic [3:0] S_REX  = 4'd6;
    localparam logic [3:0] S_RWB  = 4'd7;
    localparam logic [3:0] S_BEQ  = 4'd8;
    localparam logic [3:0] S_JMP  = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q, state_d;
    logic [5:0] op_q, op_d;      // opcode captured in ID and used to steer MADR
    logic       mem_rdy;         // effective memory-ready after the wait-enable option
    logic       op_known;        // opcode is one of the five supported classes

    // With waits disabled every memory access is assumed to finish in one cycle.
    assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // Opcode classification used by both the ID branch and the illegal-op flag.
    always_comb begin
        op_known = 1'b0;
        case (bus.op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_known = 1'b1;
            default:                              op_known = 1'b0;
        endcase
    end

    // State and latched-opcode registers; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic; unused state codes fall back to IF.
    always_comb begin
        state_d = S_IF;
        op_d    = op_q;
        case (state_q)
            S_IF: begin
                state_d = mem_rdy ? S_ID : S_IF;
            end
            S_ID: begin
                op_d = bus.op;
                case (bus.op)
                    OP_RTYPE:     state_d = S_REX;
                    OP_LW, OP_SW: state_d = S_MADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = S_IF;
                endcase
            end
            S_MADR: begin
                // Only lw or sw can reach MADR, so anything not lw is a store.
                state_d = (op_q == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                state_d = mem_rdy ? S_MWB : S_MRD;
            end
            S_MWB: begin
                state_d = S_IF;
            end
            S_MWR: begin
                state_d = mem_rdy ? S_IF : S_MWR;
            end
            S_REX: begin
                state_d = S_RWB;
            end
            S_RWB: begin
                state_d = S_IF;
            end
            S_BEQ: begin
                state_d = S_IF;
            end
            S_JMP: begin
                state_d = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Output decode from the state; write strobes are suppressed while reset is held.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.illegal_op    = 1'b0;
        case (state_q)
            S_IF: begin
                // PC+4 is computed every cycle but committed only with the IR load,
                // so the PC advances exactly once per fetch regardless of stalls.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = mem_rdy;
                bus.pc_write  = mem_rdy;
            end
            S_ID: begin
                // Speculative branch target into ALUOut.
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = ~op_known;
            end
            S_MADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_REX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            S_JMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            default: begin
            end
        endcase
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Moore FSM that sequences the multi-cycle MIPS datapath: memory, instruction register (IR), register file, program counter (PC), and ALU.
- Decodes the 6-bit opcode and drives every datapath enable and mux select.
- Drives the 2-bit ALUOp into the ALU control decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- Supports R-type, lw, sw, beq and j, with a memory-ready handshake for variable-latency memory.

Parameters:
- MEM_WAIT_EN, 1: 1 = memory states hold until mem_ready; 0 = mem_ready ignored, treated as always 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode, IR[31:26]; sampled only in ID.
- zero  in  1  ALU zero flag; used in BEQ.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero=1.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- alu_op  out  2  to ALU control decoder.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an undecoded opcode.
- state  out  4  current state, for debug.

Behaviour:
- States and encodings: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BEQ=8, JMP=9.
- Any other state code returns to IF on the next edge.
- All outputs decode combinationally from the state (plus mem_ready where noted). An output not listed for a state is 0.
- Reset: rst=1 at an edge sets state=IF, including mid-instruction. Partial results are discarded; no write is issued for the aborted instruction.
- While rst=1, every write/strobe output is forced to 0: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write.
- After reset, in IF: mem_read=1, alu_src_b=01, all other outputs 0 until mem_ready.
- IF:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - mem_ready=1 -> ID; otherwise stay in IF.
  - The PC advances exactly once per fetch.
- ID:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Transition on op: 000000 -> REX; 100011 (lw) -> MADR; 101011 (sw) -> MADR; 000100 (beq) -> BEQ; 000010 (j) -> JMP.
  - Any other op -> IF with illegal_op=1 for this ID cycle.
- MADR: alu_src_a=1, alu_src_b=10, alu_op=00. The op value latched internally at ID selects MRD (lw) or MWR (sw).
- MRD: mem_read=1, i_or_d=1. mem_ready=1 -> MWB; otherwise stay.
- MWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> IF.
- MWR: mem_write=1, i_or_d=1. mem_ready=1 -> IF; otherwise stay. mem_write is held for every wait cycle.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> IF.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> IF.
- JMP: pc_write=1, pc_source=10 -> IF.
- Latency with zero memory wait, IF through last state: R=4, lw=5, sw=4, beq=3, j=3 cycles. Each mem_ready=0 cycle in IF, MRD or MWR adds 1.
- op is latched at ID into a 6-bit register. Later changes on op do not affect MADR branching.
- MEM_WAIT_EN=0: all memory states take exactly 1 cycle; mem_ready is ignored.
- Mutual exclusion: mem_read and mem_write are never 1 together. At most one of pc_write or pc_write_cond is 1.

Test Plan:
- R-type: rst, then op=000000, mem_ready=1 -> state sequence 0,1,6,7,0. alu_op=10 in REX; reg_write=1 and reg_dst=1 only in RWB. Exactly one pc_write pulse, in IF.
- lw with memory wait: op=100011; mem_ready=0 for 2 cycles in MRD -> states 0,1,2,3,3,3,4,0. mem_read=1 and i_or_d=1 throughout MRD. reg_write=1 and mem_to_reg=1 in state 4 only.
- beq: op=000100 -> states 0,1,8,0. In BEQ, alu_op=01, pc_write_cond=1, pc_source=01. Run once with zero=1 and once with zero=0; controller outputs are identical in both runs.
- j and illegal op: op=000010 -> states 0,1,9,0 with pc_write=1, pc_source=10 in JMP. op=111111 -> states 0,1,0; illegal_op=1 for exactly one cycle; no reg_write or mem_write asserted.
- Reset mid-operation: assert rst in MWR while mem_ready=0 -> mem_write=0 immediately. Next state is 0. No reg_write or mem_write occurs before the next fetch.
- MEM_WAIT_EN=0 with mem_ready held at 0: sw completes as states 0,1,2,5,0. ir_write=1 and pc_write=1 in IF.
